// File: rtl/bf_pkg.sv
// Shared definitions for the brute-force BCD guess engine: FSM states and BCD digit constants.
package bf_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_FOUND,
    ST_EXHAUSTED
  } state_t;
endpackage

// File: rtl/bcd_incr.sv
// Combinational ripple BCD +1 across DIGITS nibbles; carry_out flags an all-9s input.
module bcd_incr
  import bf_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [DIGIT_W*DIGITS-1:0] in,
  output logic [DIGIT_W*DIGITS-1:0] out,
  output logic                      carry_out
);

  always_comb begin
    out       = in;
    carry_out = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry_out) begin
        if (in[i*DIGIT_W +: DIGIT_W] == BCD_MAX) begin
          out[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          out[i*DIGIT_W +: DIGIT_W] = in[i*DIGIT_W +: DIGIT_W] + 4'd1;
          carry_out                 = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_guess_engine.sv
// Steps a BCD candidate once per rising edge of the slow tick level and compares it
// against a latched target, reporting found/exhausted and a saturating attempt count.
module bcd_guess_engine
  import bf_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int ATT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick_in,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] target,
  output logic [DIGIT_W*DIGITS-1:0] candidate,
  output logic [ATT_W-1:0]          attempts,
  output logic                      busy,
  output logic                      found,
  output logic                      exhausted
);

  localparam int CODE_W = DIGIT_W * DIGITS;

  state_t              state;
  logic                tick_q;
  logic                tick_rise;
  logic [CODE_W-1:0]   target_q;
  logic [CODE_W-1:0]   cand_next;
  logic                cand_all9;

  bcd_incr #(.DIGITS(DIGITS)) u_incr (
    .in        (candidate),
    .out       (cand_next),
    .carry_out (cand_all9)
  );

  // tick_in is a level generated in this clock domain; only its 0->1 transition advances
  assign tick_rise = tick_in & ~tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick_q    <= 1'b0;
      target_q  <= '0;
      candidate <= '0;
      attempts  <= '0;
      busy      <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      tick_q <= tick_in;
      case (state)
        ST_SEARCH: begin
          if (tick_rise) begin
            if (attempts != '1) attempts <= attempts + ATT_W'(1);
            // Candidate freezes on the terminating compare so the readout shows it
            if (candidate == target_q) begin
              state <= ST_FOUND;
              busy  <= 1'b0;
              found <= 1'b1;
            end else if (cand_all9) begin
              state     <= ST_EXHAUSTED;
              busy      <= 1'b0;
              exhausted <= 1'b1;
            end else begin
              candidate <= cand_next;
            end
          end
        end
        default: begin
          if (start) begin
            target_q  <= target;
            candidate <= '0;
            attempts  <= '0;
            state     <= ST_SEARCH;
            busy      <= 1'b1;
            found     <= 1'b0;
            exhausted <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
